fft_stream_io: RTL



---
 rtl/fft_stream_io.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/fft_stream_io.sv
// Host-side stream load/unload engine for the radix-4 FFT core and its 4-bank RAM A.
// state  | meaning
// IDLE   | waiting for iSTART
// LOAD   | accepting N samples and scattering them across the four banks
// KICK   | one-cycle core start pulse, core owns RAM A
// RUN    | core busy; waiting for a fresh iCORE_RDY
// UNLOAD | reading results out through the output buffer
module fft_stream_io #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 9,
  parameter int RD_LAT    = 1,
  parameter int DIGIT_REV = 1,
  parameter int FILL_IM   = 0
) (
  input  logic                       iCLK,
  input  logic                       iRESET,
  input  logic                       iSTART,
  input  logic [DATA_W-1:0]          iS_DATA,
  input  logic                       iS_VALID,
  output logic                       oS_READY,
  output logic [DATA_W:0]            oM_DATA,
  output logic                       oM_VALID,
  input  logic                       iM_READY,
  output logic                       oM_LAST,
  output logic                       oSOURCE_CONT,
  output logic                       oCORE_START,
  input  logic                       iCORE_RDY,
  output logic [ADDR_W-1:0]          oADDR_WR,
  output logic [3:0]                 oWE,
  output logic [DATA_W:0]            oWDATA_RE,
  output logic [DATA_W:0]            oWDATA_IM,
  output logic [ADDR_W-1:0]          oADDR_RD,
  input  logic [4*(DATA_W+1)-1:0]    iRDATA_RE,
  output logic                       oBUSY,
  output logic                       oDONE
);

  localparam int IDX_W  = ADDR_W + 2;
  localparam int RC_W   = IDX_W + 1;
  localparam int WORD_W = DATA_W + 1;
  localparam int DEPTH  = RD_LAT + 1;
  localparam int PTR_W  = (DEPTH > 2) ? 2 : 1;
  localparam int NDIG   = IDX_W / 2;

  typedef enum logic [2:0] {IDLE, LOAD, KICK, RUN, UNLOAD} state_t;

  state_t state, state_nxt;
  logic   run_armed;

  logic [IDX_W-1:0]  in_cnt;
  logic [RC_W-1:0]   rd_cnt;
  logic [IDX_W-1:0]  rev_idx;
  logic [RD_LAT-1:0] pipe_vld;
  logic [RD_LAT-1:0] pipe_last;
  logic [1:0]        pipe_bank [RD_LAT];

  logic [WORD_W-1:0] fifo_data [DEPTH];
  logic [DEPTH-1:0]  fifo_last;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [1:0]        fifo_cnt;
  logic [1:0]        inflight;
  logic [2:0]        credit;

  logic              in_hs, issue, push, pop;
  logic [WORD_W-1:0] sample_ext, rd_word;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign in_hs      = (state == LOAD) && iS_VALID;
  assign sample_ext = {iS_DATA[DATA_W-1], iS_DATA};
  assign oWE        = in_hs ? (4'b0001 << in_cnt[1:0]) : 4'b0000;
  assign oADDR_WR   = in_cnt[IDX_W-1:2];
  assign oWDATA_RE  = in_hs ? sample_ext : '0;
  assign oWDATA_IM  = (in_hs && FILL_IM != 0) ? sample_ext : '0;

  // Unload order: plain index, or base-4 digit reversal for natural frequency order.
  always_comb begin
    rev_idx = rd_cnt[IDX_W-1:0];
    if (DIGIT_REV != 0) begin
      for (int d = 0; d < NDIG; d++) begin
        rev_idx[2*d +: 2] = rd_cnt[2*(NDIG-1-d) +: 2];
      end
    end
  end

  assign oADDR_RD = rev_idx[IDX_W-1:2];

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + 2'(pipe_vld[i]);
    end
  end

  assign oM_VALID = (fifo_cnt != 2'd0);
  assign oM_DATA  = fifo_data[rd_ptr];
  assign oM_LAST  = oM_VALID && fifo_last[rd_ptr];
  assign pop      = (state == UNLOAD) && oM_VALID && iM_READY;
  assign oDONE    = pop && fifo_last[rd_ptr];
  assign push     = pipe_vld[RD_LAT-1];
  assign rd_word  = iRDATA_RE[pipe_bank[RD_LAT-1]*WORD_W +: WORD_W];

  // A word popped this cycle frees its slot, so the credit check counts it back.
  assign credit = 3'(fifo_cnt) + 3'(inflight) - 3'(pop);
  assign issue  = (state == UNLOAD) && !rd_cnt[IDX_W] && (credit < 3'(DEPTH));
  assign oBUSY  = (state != IDLE);

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state     <= IDLE;
      run_armed <= 1'b0;
    end else begin
      state     <= state_nxt;
      run_armed <= (state == RUN);
    end
  end

  always_comb begin
    state_nxt    = state;
    oS_READY     = 1'b0;
    oSOURCE_CONT = 1'b0;
    oCORE_START  = 1'b0;
    case (state)
      IDLE: if (iSTART) state_nxt = LOAD;
      LOAD: begin
        oS_READY     = 1'b1;
        oSOURCE_CONT = 1'b1;
        if (in_hs && in_cnt == '1) state_nxt = KICK;
      end
      KICK: begin
        oCORE_START = 1'b1;
        state_nxt   = RUN;
      end
      RUN: if (run_armed && iCORE_RDY) state_nxt = UNLOAD;
      UNLOAD: begin
        oSOURCE_CONT = 1'b1;
        if (oDONE) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRESET || state == IDLE) begin
      in_cnt    <= '0;
      rd_cnt    <= '0;
      pipe_vld  <= '0;
      pipe_last <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe_bank[i] <= 2'd0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cnt  <= 2'd0;
    end else begin
      if (in_hs) in_cnt <= in_cnt + IDX_W'(1);
      if (issue) rd_cnt <= rd_cnt + RC_W'(1);
      pipe_vld[0]  <= issue;
      pipe_last[0] <= issue && (rd_cnt[IDX_W-1:0] == '1);
      pipe_bank[0] <= rev_idx[1:0];
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_last[i] <= pipe_last[i-1];
        pipe_bank[i] <= pipe_bank[i-1];
      end
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      fifo_cnt <= fifo_cnt + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      for (int i = 0; i < DEPTH; i++) fifo_data[i] <= '0;
      fifo_last <= '0;
    end else if (push) begin
      fifo_data[wr_ptr] <= rd_word;
      fifo_last[wr_ptr] <= pipe_last[RD_LAT-1];
    end
  end

endmodule
